// File: rtl/s349_divider_pkg.sv
// Shared constants for the restoring divider and its siblings (multiplier wrapper, bench).
// State encodings are plain 2-bit constants so older tools can consume them.
package s349_divider_pkg;

  localparam int NW_DEF = 8;
  localparam int DW_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_ITER = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/s349_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits and report the resulting quotient bit.
module s349_div_step #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] rem,
  input  logic          bit_in,
  input  logic [DW-1:0] div,
  output logic [DW-1:0] rem_nxt,
  output logic          qbit
);

  logic [DW:0] trial;

  assign trial = {rem, bit_in};
  assign qbit  = (trial >= {1'b0, div});
  // Whenever the divisor fits, the difference is below D and so fits in DW bits.
  assign rem_nxt = qbit ? (trial[DW-1:0] - div) : trial[DW-1:0];

endmodule

// File: rtl/s349_divider.sv
// Sequential restoring divider: NW-bit dividend over DW-bit divisor, one quotient
// bit per cycle, fixed latency, with divide-by-zero / overflow short-circuit.
module s349_divider
  import s349_divider_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          CK,
  input  logic          RESET,
  input  logic          START,
  input  logic [NW-1:0] N,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q,
  output logic [DW-1:0] R,
  output logic          BUSY,
  output logic          READY,
  output logic          ERR
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rem;
  logic [DW-1:0] sh;
  logic [DW-1:0] dreg;
  logic [DW-1:0] rem_nxt;
  logic          qbit;
  logic          accept;
  logic          bad_op;

  assign accept = START && (state != S_ITER);
  // A high half at or above D would need more than DW quotient bits.
  assign bad_op = (D == '0) || (N[NW-1:DW] >= D);

  s349_div_step #(.DW(DW)) u_step (
    .rem     (rem),
    .bit_in  (sh[DW-1]),
    .div     (dreg),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
      rem   <= '0;
      sh    <= '0;
      dreg  <= '0;
      Q     <= '0;
      R     <= '0;
      BUSY  <= 1'b0;
      READY <= 1'b0;
      ERR   <= 1'b0;
    end else if (accept) begin
      dreg <= D;
      rem  <= N[NW-1:DW];
      sh   <= N[DW-1:0];
      cnt  <= CW'(DW - 1);
      if (bad_op) begin
        state <= S_DONE;
        Q     <= '1;
        R     <= '1;
        ERR   <= 1'b1;
        READY <= 1'b1;
        BUSY  <= 1'b0;
      end else begin
        state <= S_ITER;
        ERR   <= 1'b0;
        READY <= 1'b0;
        BUSY  <= 1'b1;
      end
    end else if (state == S_ITER) begin
      // Dividend bits leave sh at the top while quotient bits enter at the bottom.
      rem <= rem_nxt;
      sh  <= {sh[DW-2:0], qbit};
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        state <= S_DONE;
        Q     <= {sh[DW-2:0], qbit};
        R     <= rem_nxt;
        BUSY  <= 1'b0;
        READY <= 1'b1;
      end
    end
  end

endmodule
